// File: rtl/ahb_lite_interconnect_param.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_interconnect_param
// Purpose  : Single-manager AHB-Lite interconnect. It decodes the address,
//            multiplexes the data-phase response, provides a built-in default
//            subordinate, and runs a per-transfer HREADYOUT timeout watchdog.
//            The watchdog quarantines a subordinate that hangs, and the
//            quarantine holds until software clears it.
// Ports    : HCLK/HRESETn            - clock, asynchronous active-low reset
//            HADDR/HTRANS/HWRITE/HSIZE - manager address-phase controls
//            HRDATA/HRESP/HREADY     - data-phase response to the manager
//            HSEL_S                  - one-hot address-phase select
//            HRDATA_S/HRESP_S/HREADYOUT_S - flattened subordinate responses
//            timeout_clr             - pulse: clear quarantine and sticky flag
//            timeout_flag/timeout_idx/quarantine - watchdog status
// Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_interconnect_param #(
    parameter int ADDR_WIDTH            = 32,
    parameter int DATA_WIDTH            = 32,
    parameter int BITS_FOR_SUBORDINATES = 2,
    parameter int NO_OF_SUBORDINATES    = 3,
    parameter int TIMEOUT_CYCLES        = 16
) (
    input  logic                                     HCLK,
    input  logic                                     HRESETn,
    input  logic [ADDR_WIDTH-1:0]                    HADDR,
    input  logic [1:0]                               HTRANS,
    input  logic                                     HWRITE,
    input  logic [2:0]                               HSIZE,
    output logic [DATA_WIDTH-1:0]                    HRDATA,
    output logic [1:0]                               HRESP,
    output logic                                     HREADY,
    output logic [NO_OF_SUBORDINATES-1:0]            HSEL_S,
    input  logic [NO_OF_SUBORDINATES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NO_OF_SUBORDINATES*2-1:0]          HRESP_S,
    input  logic [NO_OF_SUBORDINATES-1:0]            HREADYOUT_S,
    input  logic                                     timeout_clr,
    output logic                                     timeout_flag,
    output logic [BITS_FOR_SUBORDINATES-1:0]         timeout_idx,
    output logic [NO_OF_SUBORDINATES-1:0]            quarantine
);

    localparam int c_dsel_w  = BITS_FOR_SUBORDINATES + 1;
    localparam int c_wcnt_w  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_limit_i = (TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [c_wcnt_w-1:0] c_limit = c_wcnt_w'(c_limit_i);
    localparam logic [c_wcnt_w-1:0] c_wcnt_max = {c_wcnt_w{1'b1}};
    // The extra MSB of dsel marks the built-in default subordinate.
    localparam logic [c_dsel_w-1:0] c_dsel_default = {1'b1, {BITS_FOR_SUBORDINATES{1'b0}}};
    localparam logic [1:0] c_okay  = 2'b00;
    localparam logic [1:0] c_error = 2'b01;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_SUB  = 2'd1,
        D_ERR1 = 2'd2,
        D_ERR2 = 2'd3
    } state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [c_dsel_w-1:0]               r_dsel;
    logic [c_wcnt_w-1:0]               r_wcnt;
    logic [NO_OF_SUBORDINATES-1:0]     r_quarantine;
    logic                              r_timeout_flag;
    logic [BITS_FOR_SUBORDINATES-1:0]  r_timeout_idx;

    logic [BITS_FOR_SUBORDINATES-1:0]  w_dec_idx;
    logic [c_dsel_w-1:0]               w_dec_tgt;
    logic [DATA_WIDTH-1:0]             w_sub_rdata;
    logic [1:0]                        w_sub_resp;
    logic                              w_sub_ready;
    logic                              w_active;
    logic                              w_fire;
    logic                              w_unused;

    // Only the decode MSBs, HTRANS[1] and the response buses matter here.
    assign w_unused = ^{HSIZE, HWRITE, HTRANS[0], HADDR};

    assign w_dec_idx = HADDR[ADDR_WIDTH-1 -: BITS_FOR_SUBORDINATES];

    // Address decode: quarantined or out-of-range indices fall to the default.
    always_comb begin
        HSEL_S = '0;
        for (int i = 0; i < NO_OF_SUBORDINATES; i++) begin
            if ((w_dec_idx == i[BITS_FOR_SUBORDINATES-1:0]) && !r_quarantine[i]) begin
                HSEL_S[i] = 1'b1;
            end
        end
    end

    assign w_dec_tgt = (|HSEL_S) ? {1'b0, w_dec_idx} : c_dsel_default;

    // Data-phase source mux keyed by the registered select.
    always_comb begin
        w_sub_rdata = '0;
        w_sub_resp  = c_okay;
        w_sub_ready = 1'b1;
        for (int i = 0; i < NO_OF_SUBORDINATES; i++) begin
            if (r_dsel == i[c_dsel_w-1:0]) begin
                w_sub_rdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                w_sub_resp  = HRESP_S[i*2 +: 2];
                w_sub_ready = HREADYOUT_S[i];
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        HRESP  = c_okay;
        HREADY = 1'b1;
        case (r_state)
            D_SUB: begin
                HRDATA = w_sub_rdata;
                HRESP  = w_sub_resp;
                HREADY = w_sub_ready;
            end
            D_ERR1: begin
                HRESP  = c_error;
                HREADY = 1'b0;
            end
            D_ERR2: begin
                HRESP  = c_error;
            end
            default: ;
        endcase
    end

    assign w_active = HTRANS[1] & HREADY;
    assign w_fire   = (TIMEOUT_CYCLES != 0) && (r_state == D_SUB) && !w_sub_ready
                      && (r_wcnt == c_limit);

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == D_ERR1) begin
            w_state_nxt = D_ERR2;
        end else if (w_fire) begin
            w_state_nxt = D_ERR1;
        end else if (HREADY) begin
            if (!w_active) begin
                w_state_nxt = D_IDLE;
            end else if (w_dec_tgt[c_dsel_w-1]) begin
                w_state_nxt = D_ERR1;
            end else begin
                w_state_nxt = D_SUB;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= D_IDLE;
            r_dsel  <= '0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (HREADY) begin
                r_dsel <= w_dec_tgt;
            end
            if (HREADY || w_fire) begin
                r_wcnt <= '0;
            end else if ((r_state == D_SUB) && (r_wcnt != c_wcnt_max)) begin
                r_wcnt <= r_wcnt + c_wcnt_w'(1);
            end
        end
    end

    // Watchdog status: a new timeout overrides a coincident clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_quarantine   <= '0;
            r_timeout_flag <= 1'b0;
            r_timeout_idx  <= '0;
        end else begin
            if (timeout_clr) begin
                r_quarantine   <= '0;
                r_timeout_flag <= 1'b0;
                r_timeout_idx  <= '0;
            end
            if (w_fire) begin
                for (int i = 0; i < NO_OF_SUBORDINATES; i++) begin
                    if (r_dsel == i[c_dsel_w-1:0]) begin
                        r_quarantine[i] <= 1'b1;
                    end
                end
                r_timeout_flag <= 1'b1;
                r_timeout_idx  <= r_dsel[BITS_FOR_SUBORDINATES-1:0];
            end
        end
    end

    assign quarantine   = r_quarantine;
    assign timeout_flag = r_timeout_flag;
    assign timeout_idx  = r_timeout_idx;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_interconnect_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_lite_interconnect_param
// Purpose  : Directed self-checking bench for ahb_lite_interconnect_param with
//            three simple memory-backed subordinates and stall control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_interconnect_param;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;
    logic        HREADY;
    logic [2:0]  HSEL_S;
    logic [95:0] HRDATA_S;
    logic [5:0]  HRESP_S;
    logic [2:0]  HREADYOUT_S;
    logic        timeout_clr;
    logic        timeout_flag;
    logic [1:0]  timeout_idx;
    logic [2:0]  quarantine;

    logic [31:0] HWDATA;
    logic [2:0]  stall;
    int          n_vec;
    int          n_err;

    ahb_lite_interconnect_param dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HRDATA(HRDATA), .HRESP(HRESP),
        .HREADY(HREADY), .HSEL_S(HSEL_S), .HRDATA_S(HRDATA_S), .HRESP_S(HRESP_S),
        .HREADYOUT_S(HREADYOUT_S), .timeout_clr(timeout_clr),
        .timeout_flag(timeout_flag), .timeout_idx(timeout_idx), .quarantine(quarantine)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Subordinate models: 16-word memories, zero-wait unless stalled.
    logic [31:0] mem [3][16];
    logic [3:0]  ph_addr [3];
    logic [2:0]  ph_valid;
    logic [2:0]  ph_write;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ph_valid <= '0;
            ph_write <= '0;
            for (int i = 0; i < 3; i++) begin
                ph_addr[i] <= '0;
                for (int j = 0; j < 16; j++) mem[i][j] <= 32'h5000_0000 | (i << 8) | j;
            end
        end else if (HREADY) begin
            for (int i = 0; i < 3; i++) begin
                if (ph_valid[i] && ph_write[i]) mem[i][ph_addr[i]] <= HWDATA;
                ph_valid[i] <= HSEL_S[i] & HTRANS[1];
                ph_addr[i]  <= HADDR[5:2];
                ph_write[i] <= HWRITE;
            end
        end
    end

    always_comb begin
        HRDATA_S = '0;
        for (int i = 0; i < 3; i++) HRDATA_S[i*32 +: 32] = mem[i][ph_addr[i]];
    end
    assign HREADYOUT_S = ~stall;
    assign HRESP_S     = '0;

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; HADDR = 32'h4000_0000; HTRANS = 2'b10; HWRITE = 1'b0;
        #1;
        n_vec++; if (HREADY !== 1'b1) begin n_err++; $display("FAIL rst_hready: got %b want 1", HREADY); end
        n_vec++; if (HRESP !== 2'b00) begin n_err++; $display("FAIL rst_hresp: got %b want 00", HRESP); end
        n_vec++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL rst_hrdata: got %h want 0", HRDATA); end
        n_vec++; if ({timeout_flag, timeout_idx, quarantine} !== 6'b0) begin n_err++; $display("FAIL rst_wdog: got %b%b%b want 0", timeout_flag, timeout_idx, quarantine); end
        n_vec++; if (HSEL_S !== 3'b010) begin n_err++; $display("FAIL rst_hsel: got %b want 010", HSEL_S); end
        HTRANS = 2'b00;
        cyc();
        HRESETn = 1'b1;
        cyc();
    endtask

    task automatic test_write_read();
        HADDR = 32'h4000_0010; HTRANS = 2'b10; HWRITE = 1'b1; #1;
        n_vec++; if (HSEL_S !== 3'b010) begin n_err++; $display("FAIL wr_hsel: got %b want 010", HSEL_S); end
        cyc();
        HWDATA = 32'hA5A5_0001; HWRITE = 1'b0; #1;
        n_vec++; if (HREADY !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %b want 1", HREADY); end
        cyc();
        HTRANS = 2'b00; #1;
        n_vec++; if (HRDATA !== 32'hA5A5_0001) begin n_err++; $display("FAIL rd_data: got %h want a5a50001", HRDATA); end
        n_vec++; if ({HREADY, HRESP} !== 3'b100) begin n_err++; $display("FAIL rd_resp: got %b%b want 100", HREADY, HRESP); end
        cyc();
        n_vec++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL rd_idle: got %h want 0", HRDATA); end
    endtask

    task automatic test_default();
        HADDR = 32'hC000_0000; HTRANS = 2'b10; #1;
        n_vec++; if (HSEL_S !== 3'b000) begin n_err++; $display("FAIL def_hsel: got %b want 000", HSEL_S); end
        cyc();
        HTRANS = 2'b00; #1;
        n_vec++; if ({HREADY, HRESP} !== 3'b001) begin n_err++; $display("FAIL def_err1: got %b%b want 001", HREADY, HRESP); end
        cyc();
        n_vec++; if ({HREADY, HRESP} !== 3'b101) begin n_err++; $display("FAIL def_err2: got %b%b want 101", HREADY, HRESP); end
        cyc();
        n_vec++; if ({HREADY, HRESP} !== 3'b100) begin n_err++; $display("FAIL def_idle: got %b%b want 100", HREADY, HRESP); end
        cyc();
        n_vec++; if ({HREADY, HRESP} !== 3'b100) begin n_err++; $display("FAIL def_idle2: got %b%b want 100", HREADY, HRESP); end
    endtask

    task automatic test_short_stall();
        stall = 3'b100; HADDR = 32'h8000_0000; HTRANS = 2'b10; #1;
        cyc();
        HTRANS = 2'b00;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++; if (HREADY !== 1'b0) begin n_err++; $display("FAIL stall_wait%0d: got %b want 0", k, HREADY); end
            cyc();
        end
        stall = 3'b000; #1;
        n_vec++; if ({HREADY, HRESP} !== 3'b100) begin n_err++; $display("FAIL stall_done: got %b%b want 100", HREADY, HRESP); end
        n_vec++; if (HRDATA !== 32'h5000_0200) begin n_err++; $display("FAIL stall_data: got %h want 50000200", HRDATA); end
        n_vec++; if (timeout_flag !== 1'b0) begin n_err++; $display("FAIL stall_flag: got %b want 0", timeout_flag); end
        cyc();
    endtask

    task automatic test_timeout();
        int n;
        stall = 3'b001; HADDR = 32'h0000_0000; HTRANS = 2'b10; #1;
        n_vec++; if (HSEL_S !== 3'b001) begin n_err++; $display("FAIL to_hsel: got %b want 001", HSEL_S); end
        cyc();
        HTRANS = 2'b00; #1;
        n = 0;
        while (HREADY === 1'b0 && HRESP === 2'b00 && n < 40) begin n++; cyc(); end
        n_vec++; if (n !== 16) begin n_err++; $display("FAIL to_waits: got %0d want 16", n); end
        n_vec++; if ({HREADY, HRESP} !== 3'b001) begin n_err++; $display("FAIL to_err1: got %b%b want 001", HREADY, HRESP); end
        n_vec++; if ({timeout_flag, timeout_idx, quarantine} !== 6'b100001) begin n_err++; $display("FAIL to_status: got %b %b %b want 1 00 001", timeout_flag, timeout_idx, quarantine); end
        cyc();
        HTRANS = 2'b10; #1;
        n_vec++; if ({HREADY, HRESP} !== 3'b101) begin n_err++; $display("FAIL to_err2: got %b%b want 101", HREADY, HRESP); end
        n_vec++; if (HSEL_S !== 3'b000) begin n_err++; $display("FAIL to_quar_hsel: got %b want 000", HSEL_S); end
        cyc();
        HTRANS = 2'b00; #1;
        n_vec++; if ({HREADY, HRESP} !== 3'b001) begin n_err++; $display("FAIL to_quar_err: got %b%b want 001", HREADY, HRESP); end
        cyc(); cyc();
        timeout_clr = 1'b1;
        cyc();
        timeout_clr = 1'b0; #1;
        n_vec++; if ({timeout_flag, timeout_idx, quarantine} !== 6'b0) begin n_err++; $display("FAIL to_clr: got %b %b %b want 0", timeout_flag, timeout_idx, quarantine); end
        stall = 3'b000; HTRANS = 2'b10; #1;
        n_vec++; if (HSEL_S !== 3'b001) begin n_err++; $display("FAIL to_reenable: got %b want 001", HSEL_S); end
        cyc();
        HTRANS = 2'b00; #1;
        n_vec++; if (HRDATA !== 32'h5000_0000 || HREADY !== 1'b1) begin n_err++; $display("FAIL to_read: got %h/%b want 50000000/1", HRDATA, HREADY); end
        cyc();
    endtask

    task automatic test_back_to_back();
        HADDR = 32'h0000_0004; HTRANS = 2'b10; #1;
        cyc();
        HADDR = 32'h4000_0008; #1;
        n_vec++; if (HRDATA !== 32'h5000_0001 || HREADY !== 1'b1) begin n_err++; $display("FAIL b2b_s0: got %h/%b want 50000001/1", HRDATA, HREADY); end
        n_vec++; if (HSEL_S !== 3'b010) begin n_err++; $display("FAIL b2b_hsel1: got %b want 010", HSEL_S); end
        cyc();
        HADDR = 32'hC000_0000; #1;
        n_vec++; if (HRDATA !== 32'h5000_0102 || HREADY !== 1'b1) begin n_err++; $display("FAIL b2b_s1: got %h/%b want 50000102/1", HRDATA, HREADY); end
        cyc();
        HADDR = 32'h8000_000C; #1;
        n_vec++; if ({HREADY, HRESP} !== 3'b001) begin n_err++; $display("FAIL b2b_err1: got %b%b want 001", HREADY, HRESP); end
        cyc();
        n_vec++; if ({HREADY, HRESP} !== 3'b101) begin n_err++; $display("FAIL b2b_err2: got %b%b want 101", HREADY, HRESP); end
        n_vec++; if (HSEL_S !== 3'b100) begin n_err++; $display("FAIL b2b_hsel2: got %b want 100", HSEL_S); end
        cyc();
        HTRANS = 2'b00; #1;
        n_vec++; if (HRDATA !== 32'h5000_0203 || {HREADY, HRESP} !== 3'b100) begin n_err++; $display("FAIL b2b_s2: got %h/%b%b want 50000203/100", HRDATA, HREADY, HRESP); end
        cyc();
    endtask

    task automatic test_reset_mid();
        int n;
        HADDR = 32'hC000_0000; HTRANS = 2'b10; #1;
        cyc();
        HTRANS = 2'b00; #1;
        HRESETn = 1'b0; #1;
        n_vec++; if ({HREADY, HRESP} !== 3'b100) begin n_err++; $display("FAIL rerr_rst: got %b%b want 100", HREADY, HRESP); end
        cyc();
        HRESETn = 1'b1;
        cyc();
        stall = 3'b001; HADDR = 32'h0000_0000; HTRANS = 2'b10; #1;
        cyc();
        HTRANS = 2'b00;
        for (int k = 0; k < 10; k++) cyc();
        #1;
        n_vec++; if (HREADY !== 1'b0) begin n_err++; $display("FAIL rwd_pre: got %b want 0", HREADY); end
        HRESETn = 1'b0; #1;
        n_vec++; if ({HREADY, HRESP} !== 3'b100 || quarantine !== 3'b000) begin n_err++; $display("FAIL rwd_rst: got %b%b q=%b want 100 q=000", HREADY, HRESP, quarantine); end
        cyc();
        HRESETn = 1'b1;
        cyc();
        HTRANS = 2'b10; #1;
        cyc();
        HTRANS = 2'b00; #1;
        n = 0;
        while (HREADY === 1'b0 && HRESP === 2'b00 && n < 40) begin n++; cyc(); end
        n_vec++; if (n !== 16) begin n_err++; $display("FAIL rwd_waits: got %0d want 16", n); end
        n_vec++; if (timeout_flag !== 1'b1 || quarantine !== 3'b001) begin n_err++; $display("FAIL rwd_flag: got %b/%b want 1/001", timeout_flag, quarantine); end
        stall = 3'b000;
        cyc();
        timeout_clr = 1'b1;
        cyc();
        timeout_clr = 1'b0;
        cyc();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        HSIZE = 3'b010; HWDATA = 32'h0; stall = 3'b000; timeout_clr = 1'b0;
        test_reset();
        test_write_read();
        test_default();
        test_short_stall();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire

// File: doc/ahb_lite_interconnect_param.md
Name: ahb_lite_interconnect_param

Overview:
- Parametrised single-manager AHB-Lite interconnect. Replaces the fixed 3-subordinate decoder/mux/default-subordinate arrangement with one block.
- Supports NO_OF_SUBORDINATES external subordinates on flattened buses, a built-in default subordinate, a registered data-phase select, and a per-transfer HREADYOUT timeout watchdog.
- The watchdog quarantines a hung subordinate until software clears it.
- Sits between the manager (or testbench driver) and the subordinate instances.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width.
- BITS_FOR_SUBORDINATES, 2, number of HADDR MSBs used for decode.
- NO_OF_SUBORDINATES, 3, number of external subordinates. Legal range 1..2**BITS_FOR_SUBORDINATES-1.
- TIMEOUT_CYCLES, 16, number of wait-state cycles before forced ERROR. 0 disables the watchdog.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  in  ADDR_WIDTH  manager address.
- HTRANS  in  2  manager transfer type.
- HWRITE  in  1  manager write.
- HSIZE  in  3  passed through to subordinates externally; unused here.
- HRDATA  out  DATA_WIDTH  read data to manager.
- HRESP  out  2  response to manager: 2'b00 OKAY, 2'b01 ERROR.
- HREADY  out  1  ready to manager; also returned to every subordinate as HREADYin.
- HSEL_S  out  NO_OF_SUBORDINATES  one-hot address-phase select.
- HRDATA_S  in  NO_OF_SUBORDINATES*DATA_WIDTH  flattened subordinate read data; slice i = subordinate i.
- HRESP_S  in  NO_OF_SUBORDINATES*2  flattened subordinate responses.
- HREADYOUT_S  in  NO_OF_SUBORDINATES  subordinate ready outputs.
- timeout_clr  in  1  single-cycle pulse; clears quarantine and the sticky flag.
- timeout_flag  out  1  sticky; set when the watchdog fires.
- timeout_idx  out  BITS_FOR_SUBORDINATES  index of the last subordinate that timed out.
- quarantine  out  NO_OF_SUBORDINATES  per-subordinate quarantine mask.

Behaviour:
- Decode (combinational):
  - idx = HADDR[ADDR_WIDTH-1 -: BITS_FOR_SUBORDINATES].
  - HSEL_S[idx]=1 only if idx < NO_OF_SUBORDINATES and quarantine[idx]=0.
  - Otherwise the default subordinate is selected and HSEL_S is all zero.
- Active transfer: HTRANS is NONSEQ (2'b10) or SEQ (2'b11) and HREADY=1 at the HCLK rising edge.
- Data-phase select register dsel: loads the decoded target on every edge with HREADY=1; holds while HREADY=0.
- FSM states:
  - D_IDLE: HRDATA=0, HRESP=OKAY, HREADY=1.
  - D_SUB: HRDATA, HRESP and HREADY taken from subordinate slice dsel.
  - D_ERR1: HREADY=0, HRESP=ERROR, HRDATA=0.
  - D_ERR2: HREADY=1, HRESP=ERROR, HRDATA=0.
- FSM transitions on an edge with HREADY=1:
  - Active transfer to an external subordinate -> D_SUB.
  - Active transfer to the default subordinate -> D_ERR1.
  - IDLE/BUSY transfer or no transfer -> D_IDLE. IDLE/BUSY to any target gets a zero-wait OKAY.
- D_ERR1 -> D_ERR2 unconditionally. D_ERR2 behaves as HREADY=1 for the transition rules above (back-to-back transfers accepted).
- D_SUB while HREADYOUT_S[dsel]=0: wait counter wcnt increments, saturating. wcnt clears on any HREADY=1 edge.
- Watchdog fires when TIMEOUT_CYCLES != 0 and wcnt == TIMEOUT_CYCLES-1 with HREADYOUT still 0. On that edge:
  - D_SUB -> D_ERR1.
  - quarantine[dsel] <= 1, timeout_flag <= 1, timeout_idx <= dsel.
  - The manager therefore sees exactly TIMEOUT_CYCLES wait cycles, then the two-cycle ERROR.
- Late HREADYOUT/HRESP from a quarantined subordinate is ignored.
- Quarantine does not abort a transfer already in D_SUB to another index.
- timeout_clr: clears quarantine, timeout_flag and timeout_idx the next edge. If it coincides with a new timeout, the timeout wins (set has priority).
- Subordinate HRESP=ERROR in D_SUB is passed through unchanged. The subordinate owns its two-cycle ERROR sequence.
- Reset (asynchronous, any state, mid-transfer included): state=D_IDLE, dsel=0, wcnt=0, quarantine=0, timeout_flag=0, timeout_idx=0.
  - Hence HREADY=1, HRESP=OKAY, HRDATA=0.
  - HSEL_S follows HADDR combinationally even during reset.
- Width rules:
  - wcnt width = $clog2(TIMEOUT_CYCLES+1), minimum 1.
  - dsel is one bit wider than BITS_FOR_SUBORDINATES to encode the default subordinate.

Test Plan:
- Write then read 0xA5A5_0001 at HADDR=0x4000_0010 (idx 1) with a zero-wait subordinate -> HSEL_S=3'b010 in the address phase; read data phase returns 0xA5A5_0001, HRESP=OKAY, no stall.
- NONSEQ to HADDR=0xC000_0000 (idx 3, default subordinate) -> HREADY=0/ERROR, then 1/ERROR; an IDLE to the same address -> zero-wait OKAY.
- Subordinate 2 holds HREADYOUT low for 5 cycles with TIMEOUT_CYCLES=16 -> 5 waits, then normal completion; timeout_flag stays 0.
- Subordinate 0 holds HREADYOUT low indefinitely -> 16 waits, then ERROR pair; timeout_flag=1, timeout_idx=0, quarantine=3'b001. The next access to idx 0 -> HSEL_S=0 and a default ERROR. Pulse timeout_clr, then access idx 0 -> HSEL_S[0]=1.
- Back-to-back NONSEQ to idx 0, 1, default, 2 -> the data phases of each transfer route to the correct source with no lost or duplicated transfer.
- Assert HRESETn in the cycle of D_ERR1 and mid-timeout (wcnt=10) -> outputs immediately return to HREADY=1/OKAY; the watchdog restarts from 0 after release.
